// File: rtl/fifo_pkg.sv
// Constants and helpers shared by the FIFO memory and its read-side stream engine.
package fifo_pkg;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned RD_LAT    = 1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // A read may be issued only if buffered + in-flight words, after this cycle's pop, leave a free slot.
  function automatic logic room_for_read(input occ_e buf_cnt, input logic inflight, input logic pop);
    logic [2:0] occ;
    occ = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    return (occ < 3'(BUF_DEPTH));
  endfunction

endpackage

// File: rtl/stream_buf2.sv
// Two-entry ordered buffer: the head register drives the stream data directly.
module stream_buf2
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic [DATA_WIDTH-1:0] head_data,
  output occ_e                  count,
  output logic                  valid
);

  occ_e                  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  valid_q;

  // Next-state for occupancy and the two data slots; clear wins over push.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    if (clear) begin
      cnt_d = OCC_EMPTY;
    end else begin
      case (cnt_q)
        OCC_EMPTY: begin
          if (push) begin
            head_d = push_data;
            cnt_d  = OCC_ONE;
          end else begin
            cnt_d = OCC_EMPTY;
          end
        end
        OCC_ONE: begin
          if (push && pop) begin
            head_d = push_data;
          end else if (push) begin
            tail_d = push_data;
            cnt_d  = OCC_FULL;
          end else if (pop) begin
            cnt_d = OCC_EMPTY;
          end else begin
            cnt_d = OCC_ONE;
          end
        end
        OCC_FULL: begin
          if (pop) begin
            head_d = tail_q;
            if (push) begin
              tail_d = push_data;
            end else begin
              cnt_d = OCC_ONE;
            end
          end else begin
            cnt_d = OCC_FULL;
          end
        end
        default: cnt_d = OCC_EMPTY;
      endcase
    end
  end

  // State registers; valid is registered from the next occupancy so it always tracks cnt_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= (cnt_d != OCC_EMPTY);
    end
  end

  assign head_data = head_q;
  assign count     = cnt_q;
  assign valid     = valid_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a FIFO read port (one-cycle latency) into a valid/ready stream with 2-word prefetch.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  output logic                  fifo_r_en,
  input  logic [DATA_WIDTH-1:0] fifo_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  flush,
  output logic [CNT_WIDTH-1:0]  word_cnt
);

  logic [RD_LAT-1:0]    inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
  occ_e                 buf_cnt;
  logic                 pop;

  assign pop = m_valid & m_ready;

  // Occupancy counts the in-flight word so the buffer can never be pushed while full.
  assign fifo_r_en = ~rst & ~flush & ~fifo_empty & room_for_read(buf_cnt, inflight_q[0], pop);

  // Next-state for the read pipeline and the delivered-word counter.
  always_comb begin
    inflight_d = RD_LAT'(fifo_r_en);
    if (pop) begin
      word_cnt_d = word_cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  // Read-pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      word_cnt_q <= '0;
    end else begin
      inflight_q <= inflight_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  stream_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (flush),
    .push     (inflight_q[0]),
    .pop      (pop),
    .push_data(fifo_rdata),
    .head_data(m_data),
    .count    (buf_cnt),
    .valid    (m_valid)
  );

  assign word_cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: a queue-based FIFO model feeds the reader; delivered words are checked in order.
module tb_fifo_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, fifo_empty, m_ready, flush;
  logic [7:0] fifo_rdata;
  wire        fifo_r_en, m_valid;
  wire  [7:0] m_data;
  wire [15:0] word_cnt;
  wire        w_r_en, w_m_valid;
  wire  [7:0] w_m_data;
  wire  [3:0] w_word_cnt;

  int checks = 0;
  int failures = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic hold_empty;
  logic last_en, popped;
  int rd_pulses;

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
    .fifo_rdata(fifo_rdata), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .flush(flush), .word_cnt(word_cnt)
  );

  fifo_stream_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut_wrap (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_r_en(w_r_en),
    .fifo_rdata(fifo_rdata), .m_valid(w_m_valid), .m_ready(m_ready),
    .m_data(w_m_data), .flush(flush), .word_cnt(w_word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = hold_empty | (fifo_q.size() == 0);
  endtask

  task automatic push_words(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(first + 8'(i));
      exp_q.push_back(first + 8'(i));
    end
    upd_empty();
  endtask

  // One clock: sample at negedge, then update the FIFO model just after the posedge.
  task automatic cycle();
    logic en, pop;
    logic [7:0] d, e;
    @(negedge clk);
    en = fifo_r_en;
    pop = m_valid & m_ready;
    d = m_data;
    last_en = en;
    popped = pop;
    check("wrap_inst_ren", w_r_en, en);
    if (en) begin
      rd_pulses++;
      check("read_while_empty", fifo_empty, 1'b0);
    end
    if (pop) begin
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
      check("word_order", d, e);
    end
    @(posedge clk);
    #1;
    if (en) begin
      fifo_rdata = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'hxx;
    end
    upd_empty();
  endtask

  initial begin
    int first_pop, last_pop, npop;
    rst = 1'b1; flush = 1'b0; m_ready = 1'b1; hold_empty = 1'b0;
    fifo_rdata = 8'h00; rd_pulses = 0;
    push_words(8'h01, 16);

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_ren", fifo_r_en, 1'b0);
      check("rst_valid", m_valid, 1'b0);
      check("rst_data", m_data, 8'h00);
      check("rst_cnt", word_cnt, 16'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    first_pop = -1; last_pop = -1; npop = 0;
    for (int i = 0; i < 18; i++) begin
      cycle();
      if (i == 0) check("first_ren", last_en, 1'b1);
      if (popped) begin
        if (first_pop < 0) first_pop = i;
        last_pop = i;
        npop++;
      end
    end
    check("first_pop_cycle", first_pop, 2);
    check("last_pop_cycle", last_pop, 17);
    check("stream_pops", npop, 16);
    check("stream_cnt", word_cnt, 16'd16);
    check("stream_cnt_wrap4", w_word_cnt, 4'd0);
    check("drained_valid", m_valid, 1'b0);

    push_words(8'h11, 16);
    for (int i = 0; i < 3; i++) cycle();
    check("cnt_17", word_cnt, 16'd17);
    check("wrap_reads_1", w_word_cnt, 4'd1);
    for (int i = 0; i < 3; i++) cycle();
    check("pre_stall_cnt", word_cnt, 16'd20);

    m_ready = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_data", m_data, 8'h15);
      check("stall_valid", m_valid, 1'b1);
    end
    check("stall_reads_le2", (rd_pulses <= 2), 1'b1);
    check("stall_cnt", word_cnt, 16'd20);
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) cycle();
    check("bp_all_delivered", exp_q.size(), 0);
    check("bp_cnt", word_cnt, 16'd32);

    push_words(8'h21, 8);
    hold_empty = 1'b1;
    for (int i = 0; i < 40; i++) begin
      hold_empty = ~hold_empty;
      upd_empty();
      cycle();
    end
    hold_empty = 1'b0;
    upd_empty();
    check("toggle_all_delivered", exp_q.size(), 0);
    check("toggle_cnt", word_cnt, 16'd40);

    push_words(8'h31, 10);
    for (int i = 0; i < 4; i++) cycle();
    check("pre_flush_head", m_data, 8'h33);
    check("pre_flush_cnt", word_cnt, 16'd42);
    flush = 1'b1;
    rd_pulses = 0;
    cycle();
    flush = 1'b0;
    check("flush_no_read", rd_pulses, 0);
    void'(exp_q.pop_front());
    check("flush_valid", m_valid, 1'b0);
    check("flush_cnt", word_cnt, 16'd43);
    cycle();
    check("post_flush_valid", m_valid, 1'b0);
    for (int i = 0; i < 12; i++) cycle();
    check("flush_rest_delivered", exp_q.size(), 0);
    check("final_cnt", word_cnt, 16'd49);
    check("final_cnt_wrap4", w_word_cnt, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
